// File: rtl/hs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hs_pkg
// Description : Shared types and default sizes for the high-score table
//               update controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hs_pkg;

  localparam int HS_ENTRIES = 3;
  localparam int HS_DATA_W  = 32;
  localparam int HS_ADDR_W  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hs_rank_calc.sv
`default_nettype none
// ============================================================================
// Module      : hs_rank_calc
// Description : Combinational insertion rank of a score against a descending
//               table. Rank = number of entries >= score, so a tie leaves the
//               existing holder above the new score. Rank N_ENTRIES means the
//               score does not qualify.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rank_calc
  import hs_pkg::*;
#(
  parameter int N_ENTRIES = HS_ENTRIES,
  parameter int DATA_W    = HS_DATA_W,
  parameter int ADDR_W    = HS_ADDR_W
) (
  input  logic [DATA_W-1:0]                 i_score,
  input  logic [N_ENTRIES-1:0][DATA_W-1:0]  i_entries,
  output logic [ADDR_W-1:0]                 o_rank
);

  localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

  // Count entries that hold on to their place against the new score
  always_comb begin
    o_rank = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (i_entries[i] >= i_score) begin
        o_rank = o_rank + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hs_table_updater.sv
`default_nettype none
// ============================================================================
// Module      : hs_table_updater
// Description : Write-side controller for the high-score RAM. On a final
//               score it reads the whole table, finds the insertion rank,
//               shifts lower entries down bottom-up and writes the new score.
//               While idle, display read requests pass straight to the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_table_updater
  import hs_pkg::*;
#(
  parameter int N_ENTRIES = HS_ENTRIES,
  parameter int DATA_W    = HS_DATA_W,
  parameter int ADDR_W    = HS_ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] score_in,
  input  logic              score_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rank,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  localparam logic [ADDR_W-1:0] c_N    = ADDR_W'(N_ENTRIES);
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N_ENTRIES - 1);
  localparam logic [ADDR_W-1:0] c_ONE  = ADDR_W'(1);

  state_t                              r_state;
  logic [ADDR_W-1:0]                   r_rd_cnt;
  logic [ADDR_W-1:0]                   r_wr_idx;
  logic [ADDR_W-1:0]                   r_rank;
  logic [DATA_W-1:0]                   r_score;
  logic [N_ENTRIES-1:0][DATA_W-1:0]    r_entry;

  logic [ADDR_W-1:0]                   w_rank_n;
  logic [ADDR_W-1:0]                   w_prev_idx;

  hs_rank_calc #(
    .N_ENTRIES (N_ENTRIES),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W)
  ) u_rank_calc (
    .i_score   (r_score),
    .i_entries (r_entry),
    .o_rank    (w_rank_n)
  );

  // Control sequence: latch score, read table, rank it, shift-write, finish
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_rd_cnt <= '0;
      r_wr_idx <= '0;
      r_rank   <= c_N;
      r_score  <= '0;
      r_entry  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (score_valid) begin
            r_score  <= score_in;
            r_rd_cnt <= '0;
            r_state  <= READ;
          end
        end
        READ: begin
          // Read data lags the address by one cycle, hence the -1 slot
          if (r_rd_cnt != '0) begin
            r_entry[r_rd_cnt - c_ONE] <= ram_rdata;
          end
          if (r_rd_cnt == c_N) begin
            r_state <= COMPARE;
          end else begin
            r_rd_cnt <= r_rd_cnt + c_ONE;
          end
        end
        COMPARE: begin
          r_rank <= w_rank_n;
          if (w_rank_n == c_N) begin
            r_state <= DONE;
          end else begin
            r_wr_idx <= c_LAST;
            r_state  <= WRITE;
          end
        end
        WRITE: begin
          if (r_wr_idx == r_rank) begin
            r_state <= DONE;
          end else begin
            r_wr_idx <= r_wr_idx - c_ONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_prev_idx = r_wr_idx - c_ONE;

  // Status and write port decode purely from registered state (Moore)
  always_comb begin
    busy      = (r_state != IDLE);
    done      = (r_state == DONE);
    rank      = r_rank;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (r_state == WRITE) begin
      ram_we    = 1'b1;
      ram_waddr = r_wr_idx;
      // The slot at the insertion rank takes the new score; every slot below
      // takes the entry that was one rank above it
      ram_wdata = (r_wr_idx == r_rank) ? r_score : r_entry[w_prev_idx];
    end
  end

  // Read address: display pass-through while idle, table scan while reading
  always_comb begin
    ram_raddr = '0;
    case (r_state)
      IDLE:    ram_raddr = disp_addr;
      READ:    ram_raddr = (r_rd_cnt < c_N) ? r_rd_cnt : '0;
      default: ram_raddr = '0;
    endcase
  end

  assign disp_data = ram_rdata;

endmodule
`default_nettype wire
